// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count, encoded floor width and the
// symbolic floor codes used by the request decoder, the priority encoder
// and the benches.
package elevator_pkg;

  localparam int unsigned N_FLOORS = 4;
  localparam int unsigned FLOOR_W  = 2;

  typedef enum logic [FLOOR_W-1:0] {
    FLOOR_A = 2'b00,
    FLOOR_B = 2'b01,
    FLOOR_C = 2'b10,
    FLOOR_D = 2'b11
  } floor_e;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational binary-to-one-hot decoder with enable.
//   i_en     : when low the output is all zeros
//   i_code   : IN_W-bit binary index
//   o_onehot : N_OUT-bit vector with bit i_code set (if enabled)
module onehot_decoder #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned IN_W  = 2
) (
  input  logic              i_en,
  input  logic [IN_W-1:0]   i_code,
  output logic [N_OUT-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/floor_request_decoder.sv
// Registered floor request decoder. Encoded floor requests pass through a
// one-entry staging register and are OR-ed into a per-floor pending vector;
// service events clear pending bits. Also reports duplicate requests and a
// registered count of pending floors.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : request offered;  req_floor : encoded floor of request
//   req_ready    : request accepted this cycle when req_valid is high
//   hold         : freeze commits from the staging register
//   srv_valid    : floor serviced;   srv_floor : encoded serviced floor
//   pending      : bit i set = floor i has an outstanding request
//   pending_cnt  : number of set bits in pending
//   dup          : one-cycle pulse, committed request was already pending
module floor_request_decoder #(
  parameter int unsigned N_FLOORS = elevator_pkg::N_FLOORS,
  parameter int unsigned FLOOR_W  = elevator_pkg::FLOOR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  output logic                req_ready,
  input  logic                hold,
  input  logic                srv_valid,
  input  logic [FLOOR_W-1:0]  srv_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic [FLOOR_W:0]    pending_cnt,
  output logic                dup
);

  logic                r_stg_valid;
  logic [FLOOR_W-1:0]  r_stg_floor;
  logic [N_FLOORS-1:0] r_pending;
  logic [FLOOR_W:0]    r_pending_cnt;
  logic                r_dup;

  logic                w_accept;
  logic                w_commit;
  logic [N_FLOORS-1:0] w_set_vec;
  logic [N_FLOORS-1:0] w_clr_vec;
  logic [N_FLOORS-1:0] w_pending_nxt;
  logic [FLOOR_W:0]    w_cnt_nxt;
  logic                w_dup_nxt;

  // Staging register is empty, or it drains this cycle.
  assign req_ready = !r_stg_valid || !hold;
  assign w_accept  = req_valid && req_ready;
  assign w_commit  = r_stg_valid && !hold;

  onehot_decoder #(.N_OUT(N_FLOORS), .IN_W(FLOOR_W)) u_set_dec (
    .i_en     (w_commit),
    .i_code   (r_stg_floor),
    .o_onehot (w_set_vec)
  );

  onehot_decoder #(.N_OUT(N_FLOORS), .IN_W(FLOOR_W)) u_clr_dec (
    .i_en     (srv_valid),
    .i_code   (srv_floor),
    .o_onehot (w_clr_vec)
  );

  // Clear wins over set: the car is at the floor, so the request is met.
  assign w_pending_nxt = (r_pending | w_set_vec) & ~w_clr_vec;

  // A request colliding with service of the same floor is not a duplicate.
  assign w_dup_nxt = w_commit && r_pending[r_stg_floor] && !w_clr_vec[r_stg_floor];

  always_comb begin
    w_cnt_nxt = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (FLOOR_W+1)'(w_pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg_valid   <= 1'b0;
      r_stg_floor   <= '0;
      r_pending     <= '0;
      r_pending_cnt <= '0;
      r_dup         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_stg_valid <= 1'b1;
        r_stg_floor <= req_floor;
      end else if (w_commit) begin
        r_stg_valid <= 1'b0;
      end
      r_pending     <= w_pending_nxt;
      r_pending_cnt <= w_cnt_nxt;
      r_dup         <= w_dup_nxt;
    end
  end

  assign pending     = r_pending;
  assign pending_cnt = r_pending_cnt;
  assign dup         = r_dup;

endmodule

// File: tb/tb_floor_request_decoder.sv
module tb_floor_request_decoder;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_floor;
  logic       req_ready;
  logic       hold;
  logic       srv_valid;
  logic [1:0] srv_floor;
  logic [3:0] pending;
  logic [2:0] pending_cnt;
  logic       dup;

  int errors = 0;
  int checks = 0;

  floor_request_decoder #(.N_FLOORS(4), .FLOOR_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_floor   (req_floor),
    .req_ready   (req_ready),
    .hold        (hold),
    .srv_valid   (srv_valid),
    .srv_floor   (srv_floor),
    .pending     (pending),
    .pending_cnt (pending_cnt),
    .dup         (dup)
  );

  always #5 clk = ~clk;

  // Reference model: a set of pending floors and a queue holding at most one
  // staged request.
  bit m_pend[4];
  int m_stg[$];
  bit m_dup;

  function automatic void model_reset();
    m_stg.delete();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_dup = 0;
  endfunction

  function automatic bit model_ready();
    return (m_stg.size() == 0) || !hold;
  endfunction

  function automatic void model_edge();
    bit rdy;
    bit com;
    int f;
    rdy = model_ready();
    com = (m_stg.size() != 0) && !hold;
    f   = com ? m_stg[0] : 0;
    m_dup = com && m_pend[f] && !(srv_valid && int'(srv_floor) == f);
    if (com) begin
      m_pend[f] = 1;
      void'(m_stg.pop_front());
    end
    if (srv_valid) m_pend[int'(srv_floor)] = 0;
    if (req_valid && rdy) m_stg.push_back(int'(req_floor));
  endfunction

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int model_cnt();
    int n = 0;
    foreach (m_pend[i]) n += m_pend[i];
    return n;
  endfunction

  // Advance one clock edge with the model tracking the same inputs.
  task automatic step();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; req_floor = 0; hold = 0; srv_valid = 0; srv_floor = 0;
  endtask

  task automatic req(input logic [1:0] f);
    req_valid = 1; req_floor = f;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b expected 0", dup); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    rst_n = 1;
    step();
    // Mid-stream reset with a staged request, plus one already pending.
    req(FLOOR_A); step();
    req(FLOOR_C); step();
    idle(); hold = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midreset_pending: got %b expected 0000", pending); end
    checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL midreset_cnt: got %0d expected 0", pending_cnt); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", req_ready); end
    rst_n = 1;
    hold = 0;
    repeat (3) step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL midreset_staged_lost: got %b expected 0000", pending); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_p[4];
    logic [1:0] fl[4];
    exp_p[0] = 4'b0000; exp_p[1] = 4'b0100; exp_p[2] = 4'b0101; exp_p[3] = 4'b1101;
    fl[0] = FLOOR_C; fl[1] = FLOOR_A; fl[2] = FLOOR_D; fl[3] = FLOOR_A;
    idle();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) req(fl[i]); else req_valid = 0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
      step();
      checks++; if (pending !== exp_p[i]) begin errors++; $display("FAIL b2b_pending[%0d]: got %b expected %b", i, pending, exp_p[i]); end
    end
    checks++; if (pending_cnt !== 3'd3) begin errors++; $display("FAIL b2b_cnt: got %0d expected 3", pending_cnt); end
    // Service everything back out.
    srv_valid = 1; srv_floor = FLOOR_A; step();
    srv_floor = FLOOR_C; step();
    srv_floor = FLOOR_D; step();
    idle();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL b2b_cleanup: got %b expected 0000", pending); end
  endtask

  task automatic test_dup();
    idle();
    req(FLOOR_B); step();
    idle(); step();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL dup_setup: got %b expected 0010", pending); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL dup_first: got %b expected 0", dup); end
    req(FLOOR_B); step();
    idle(); step();
    checks++; if (dup !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b expected 1", dup); end
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL dup_pending: got %b expected 0010", pending); end
    checks++; if (pending_cnt !== 3'd1) begin errors++; $display("FAIL dup_cnt: got %0d expected 1", pending_cnt); end
    step();
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL dup_one_cycle: got %b expected 0", dup); end
    srv_valid = 1; srv_floor = FLOOR_B; step();
    idle();
  endtask

  task automatic test_collision();
    idle();
    req(FLOOR_D); step();
    idle(); srv_valid = 1; srv_floor = FLOOR_D; step();
    idle();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL coll_empty_pending: got %b expected 0000", pending); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL coll_empty_dup: got %b expected 0", dup); end
    req(FLOOR_D); step();
    idle(); step();
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL coll_setup: got %b expected 1000", pending); end
    req(FLOOR_D); step();
    idle(); srv_valid = 1; srv_floor = FLOOR_D; step();
    idle();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL coll_full_pending: got %b expected 0000", pending); end
    checks++; if (dup !== 1'b0) begin errors++; $display("FAIL coll_full_dup: got %b expected 0", dup); end
    checks++; if (pending_cnt !== 3'd0) begin errors++; $display("FAIL coll_full_cnt: got %0d expected 0", pending_cnt); end
  endtask

  task automatic test_hold();
    idle();
    req(FLOOR_A); step();
    idle(); step();
    hold = 1; req(FLOOR_B); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_empty: got %b expected 1", req_ready); end
    step();
    req(FLOOR_C); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_staged: got %b expected 0", req_ready); end
    step();
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL hold_frozen: got %b expected 0001", pending); end
    srv_valid = 1; srv_floor = FLOOR_A; step();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL hold_service: got %b expected 0000", pending); end
    srv_valid = 0; hold = 0; #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b expected 1", req_ready); end
    step();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL hold_commit_b: got %b expected 0010", pending); end
    idle(); step();
    checks++; if (pending !== 4'b0110) begin errors++; $display("FAIL hold_commit_c: got %b expected 0110", pending); end
    srv_valid = 1; srv_floor = FLOOR_B; step();
    srv_floor = FLOOR_C; step();
    idle();
  endtask

  task automatic test_drain();
    logic [1:0] fl;
    idle();
    for (int i = 0; i < 4; i++) begin
      fl = 2'(i);
      req(fl); step();
    end
    idle(); step();
    checks++; if (pending !== 4'b1111 || pending_cnt !== 3'd4) begin
      errors++; $display("FAIL drain_full: got %b/%0d expected 1111/4", pending, pending_cnt);
    end
    for (int i = 3; i >= 0; i--) begin
      srv_valid = 1; srv_floor = 2'(i); step();
      checks++; if (pending_cnt !== 3'(i)) begin errors++; $display("FAIL drain_cnt[%0d]: got %0d expected %0d", i, pending_cnt, i); end
    end
    idle();
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL drain_end: got %b expected 0000", pending); end
  endtask

  task automatic test_random();
    bit stalled = 0;
    idle();
    for (int n = 0; n < 600; n++) begin
      if (!stalled) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_floor = 2'($urandom_range(0, 3));
      end
      hold      = ($urandom_range(0, 9) < 3);
      srv_valid = ($urandom_range(0, 2) == 0);
      srv_floor = 2'($urandom_range(0, 3));
      #1;
      checks++; if (req_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, req_ready, model_ready()); end
      stalled = req_valid && !model_ready();
      step();
      checks++; if (pending !== model_vec()) begin errors++; $display("FAIL rnd_pending[%0d]: got %b expected %b", n, pending, model_vec()); end
      checks++; if (int'(pending_cnt) != model_cnt()) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", n, pending_cnt, model_cnt()); end
      checks++; if (dup !== m_dup) begin errors++; $display("FAIL rnd_dup[%0d]: got %b expected %b", n, dup, m_dup); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_dup();
    test_collision();
    test_hold();
    test_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
